// File: rtl/regbank_read_port_if.sv
// Read-port handshake bundle: request (two operand addresses) in, registered operand pair out.
// master = requester/consumer side, slave = the read port.
interface regbank_read_port_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr_a;
  logic [ADDR_W-1:0] req_addr_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data_a;
  logic [DATA_W-1:0] rsp_data_b;

  modport master (
    output req_valid, req_addr_a, req_addr_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  req_valid, req_addr_a, req_addr_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/regbank_read_port.sv
// Register bank read port: two operands by address into a one-entry output stage; REGBANK_RD_BYPASS_EN forwards same-cycle writes.
// Latency 1 cycle, 1 pair/cycle; req_ready = empty | rsp_ready, so a stalled consumer stalls the requester.
module regbank_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [DATA_W*(2**ADDR_W)-1:0] regs_flat_i,
  input  logic                          wr_en_i,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  regbank_read_port_if.slave            rd_if
);

`ifdef REGBANK_RD_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } opnd_t;

  logic [0:0] state_q, state_d;
  opnd_t      opnd_q, opnd_d;
  logic       req_fire;

  // Register 0 is hard zero and wins over any bypass hit.
  function automatic logic [DATA_W-1:0] read_opnd(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs_flat_i[int'(addr)*DATA_W +: DATA_W];
    if (BYPASS_EN && wr_en_i && (wr_addr_i == addr)) val = wr_data_i;
    if (addr == '0) val = '0;
    return val;
  endfunction

  assign rd_if.req_ready = (state_q == ST_EMPTY) | rd_if.rsp_ready;
  assign req_fire        = rd_if.req_valid & rd_if.req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (rd_if.req_valid) state_d = ST_FULL;
      ST_FULL:  if (rd_if.rsp_ready && !rd_if.req_valid) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    opnd_d = opnd_q;
    if (req_fire) begin
      opnd_d.a = read_opnd(rd_if.req_addr_a);
      opnd_d.b = read_opnd(rd_if.req_addr_b);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
    end
  end

  assign rd_if.rsp_valid  = (state_q == ST_FULL);
  assign rd_if.rsp_data_a = opnd_q.a;
  assign rd_if.rsp_data_b = opnd_q.b;

endmodule

// File: tb/tb_regbank_read_port.sv
// Directed bench for regbank_read_port: reset, reads, zero reg, backpressure, back-to-back, bypass.
module tb_regbank_read_port;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2**ADDR_W;

  logic                     clk_i;
  logic                     rst_n_i;
  logic [DATA_W*NREG-1:0]   regs_flat;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  int n_checks = 0;
  int n_errors = 0;

  regbank_read_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rd_if ();

  regbank_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .regs_flat_i (regs_flat),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_if       (rd_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    regs_flat[idx*DATA_W +: DATA_W] = v;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] byp_exp;

  initial begin
    rst_n_i          = 1'b0;
    regs_flat        = '0;
    wr_en            = 1'b0;
    wr_addr          = '0;
    wr_data          = '0;
    rd_if.req_valid  = 1'b0;
    rd_if.req_addr_a = '0;
    rd_if.req_addr_b = '0;
    rd_if.rsp_ready  = 1'b0;

    #12;
    chk("rst_vld", {31'd0, rd_if.rsp_valid}, 32'd0);
    chk("rst_a", rd_if.rsp_data_a, 32'd0);
    chk("rst_b", rd_if.rsp_data_b, 32'd0);
    #10 rst_n_i = 1'b1;
    #1;
    chk("rst_rdy", {31'd0, rd_if.req_ready}, 32'd1);

    // basic read, high address included
    set_reg(5, 32'hDEADBEEF);
    set_reg(31, 32'h00000001);
    rd_if.req_addr_a = 5'd5;
    rd_if.req_addr_b = 5'd31;
    rd_if.req_valid  = 1'b1;
    rd_if.rsp_ready  = 1'b1;
    tick();
    chk("rd_vld", {31'd0, rd_if.rsp_valid}, 32'd1);
    chk("rd_a", rd_if.rsp_data_a, 32'hDEADBEEF);
    chk("rd_b", rd_if.rsp_data_b, 32'h00000001);
    rd_if.req_valid = 1'b0;
    tick();
    chk("rd_drain", {31'd0, rd_if.rsp_valid}, 32'd0);

    // zero register
    set_reg(0, 32'hFFFFFFFF);
    rd_if.req_addr_a = 5'd0;
    rd_if.req_addr_b = 5'd0;
    rd_if.req_valid  = 1'b1;
    tick();
    chk("zero_a", rd_if.rsp_data_a, 32'd0);
    chk("zero_b", rd_if.rsp_data_b, 32'd0);
    rd_if.req_valid = 1'b0;
    tick();

    // backpressure: held data must not follow later array changes
    set_reg(10, 32'h11111111);
    rd_if.req_addr_a = 5'd10;
    rd_if.req_addr_b = 5'd10;
    rd_if.req_valid  = 1'b1;
    tick();
    rd_if.rsp_ready = 1'b0;
    set_reg(10, 32'h22222222);
    #1;
    chk("bp_rdy", {31'd0, rd_if.req_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_vld", {31'd0, rd_if.rsp_valid}, 32'd1);
      chk("bp_hold", rd_if.rsp_data_a, 32'h11111111);
      set_reg(10, 32'h33333333 + i);
    end
    set_reg(10, 32'h55555555);
    rd_if.rsp_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", {31'd0, rd_if.req_ready}, 32'd1);
    tick();
    chk("bp_new_a", rd_if.rsp_data_a, 32'h55555555);
    chk("bp_new_b", rd_if.rsp_data_b, 32'h55555555);
    rd_if.req_valid = 1'b0;
    tick();
    chk("bp_drain", {31'd0, rd_if.rsp_valid}, 32'd0);

    // back-to-back
    for (int i = 1; i <= 4; i++) begin
      set_reg(i, 32'h00000100 + i);
      set_reg(i + 10, 32'h00000200 + i);
    end
    for (int i = 1; i <= 4; i++) begin
      rd_if.req_addr_a = ADDR_W'(i);
      rd_if.req_addr_b = ADDR_W'(i + 10);
      rd_if.req_valid  = 1'b1;
      tick();
      chk("b2b_vld", {31'd0, rd_if.rsp_valid}, 32'd1);
      chk("b2b_a", rd_if.rsp_data_a, 32'h00000100 + i);
      chk("b2b_b", rd_if.rsp_data_b, 32'h00000200 + i);
    end
    rd_if.req_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, rd_if.rsp_valid}, 32'd0);

    // same-cycle write forwarding
`ifdef REGBANK_RD_BYPASS_EN
    byp_exp = 32'hCAFE0000;
`else
    byp_exp = 32'h00000000;
`endif
    set_reg(7, 32'h00000000);
    wr_en            = 1'b1;
    wr_addr          = 5'd7;
    wr_data          = 32'hCAFE0000;
    rd_if.req_addr_a = 5'd7;
    rd_if.req_addr_b = 5'd3;
    rd_if.req_valid  = 1'b1;
    tick();
    chk("byp_a", rd_if.rsp_data_a, byp_exp);
    chk("byp_b_other", rd_if.rsp_data_b, 32'h00000103);
    rd_if.req_addr_a = 5'd2;
    rd_if.req_addr_b = 5'd7;
    tick();
    chk("byp_a_other", rd_if.rsp_data_a, 32'h00000102);
    chk("byp_b", rd_if.rsp_data_b, byp_exp);
    wr_addr          = 5'd0;
    rd_if.req_addr_a = 5'd0;
    rd_if.req_addr_b = 5'd0;
    tick();
    chk("byp_zero_a", rd_if.rsp_data_a, 32'd0);
    chk("byp_zero_b", rd_if.rsp_data_b, 32'd0);
    wr_en = 1'b0;
    rd_if.req_valid = 1'b0;
    tick();

    // reset mid-FULL drops the response immediately
    rd_if.req_addr_a = 5'd5;
    rd_if.req_addr_b = 5'd31;
    rd_if.req_valid  = 1'b1;
    rd_if.rsp_ready  = 1'b0;
    tick();
    chk("mid_vld", {31'd0, rd_if.rsp_valid}, 32'd1);
    chk("mid_a", rd_if.rsp_data_a, 32'hDEADBEEF);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_vld", {31'd0, rd_if.rsp_valid}, 32'd0);
    chk("arst_a", rd_if.rsp_data_a, 32'd0);
    chk("arst_b", rd_if.rsp_data_b, 32'd0);
    rd_if.req_valid = 1'b0;
    #3 rst_n_i = 1'b1;
    #1;
    chk("arst_rdy", {31'd0, rd_if.req_ready}, 32'd1);
    tick();
    chk("arst_post_vld", {31'd0, rd_if.rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
